// File: rtl/seg7_disp_ctrl_if.sv
// Request/display bundle between the operation/countdown requester and the
// 7-segment display controller.
interface seg7_disp_ctrl_if;
    logic       i_op_valid;
    logic [2:0] i_op_code;
    logic       o_op_ready;
    logic       i_cd_start;
    logic [3:0] i_cd_secs;
    logic       i_cd_cancel;
    logic       o_en;
    logic       o_disp_mode;
    logic [2:0] o_op_code;
    logic [3:0] o_digit_val;
    logic       o_busy;
    logic       o_cd_done;

    modport master (
        output i_op_valid, i_op_code, i_cd_start, i_cd_secs, i_cd_cancel,
        input  o_op_ready, o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_cd_done
    );

    modport slave (
        input  i_op_valid, i_op_code, i_cd_start, i_cd_secs, i_cd_cancel,
        output o_op_ready, o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_cd_done
    );
endinterface

// File: rtl/seg7_disp_ctrl.sv
// Display controller: shows an operation symbol or a 9..0 countdown digit,
// returning to the prior symbol/blank state when the countdown ends.
module seg7_disp_ctrl #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    seg7_disp_ctrl_if.slave  bus
);

    localparam int unsigned TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DIGIT_W  = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        CD   = 2'd2
    } state_t;

    state_t              state;
    state_t              ret_state;
    logic [TICK_W-1:0]   tick;
    logic [DIGIT_W-1:0]  count;
    logic [2:0]          op_code;
    logic                en_r;
    logic                mode_r;
    logic                busy_r;
    logic                done_r;
    logic                ready_r;

    logic                op_hs_c;
    logic                tick_last_c;
    logic [DIGIT_W-1:0]  load_val_c;

    assign op_hs_c     = bus.i_op_valid && ready_r;
    assign tick_last_c = (tick == TICK_W'(TICK_CYCLES - 1));
    assign load_val_c  = (bus.i_cd_secs > DIGIT_MAX) ? DIGIT_MAX : bus.i_cd_secs;

    // Mode FSM; display outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            tick      <= '0;
            count     <= '0;
            op_code   <= '0;
            en_r      <= 1'b0;
            mode_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE, OP: begin
                    if (op_hs_c) begin
                        op_code <= bus.i_op_code;
                    end
                    if (bus.i_cd_start && !bus.i_cd_cancel) begin
                        state     <= CD;
                        ret_state <= (op_hs_c || state == OP) ? OP : IDLE;
                        count     <= load_val_c;
                        tick      <= '0;
                        en_r      <= 1'b1;
                        mode_r    <= 1'b1;
                        busy_r    <= 1'b1;
                        ready_r   <= 1'b0;
                    end else if (op_hs_c) begin
                        state   <= OP;
                        en_r    <= 1'b1;
                        mode_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                CD: begin
                    // Cancel beats restart; a restart keeps the recorded return state.
                    if (bus.i_cd_cancel || (tick_last_c && count == '0 && !bus.i_cd_start)) begin
                        state   <= ret_state;
                        en_r    <= (ret_state == OP);
                        mode_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                        tick    <= '0;
                        done_r  <= !bus.i_cd_cancel;
                    end else if (bus.i_cd_start) begin
                        count <= load_val_c;
                        tick  <= '0;
                    end else if (tick_last_c) begin
                        tick  <= '0;
                        count <= count - DIGIT_W'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_op_ready  = ready_r;
    assign bus.o_en        = en_r;
    assign bus.o_disp_mode = mode_r;
    assign bus.o_op_code   = op_code;
    assign bus.o_digit_val = count;
    assign bus.o_busy      = busy_r;
    assign bus.o_cd_done   = done_r;

endmodule

// File: doc/seg7_disp_ctrl.md
SEG7_DISP_CTRL -- requirements
Module: seg7_disp_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100_000_000, meaning clock cycles per countdown step (1 s at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_op_valid, input, 1 bit: request to show an operation symbol.
REQ-005 SHALL have port i_op_code, input, 3 bits: symbol code, 000=T, 001=A, 010=C, 011=B; sampled on acceptance.
REQ-006 SHALL have port o_op_ready, output, 1 bit: the op request is accepted when i_op_valid and o_op_ready are both 1.
REQ-007 SHALL have port i_cd_start, input, 1 bit: single-cycle pulse that starts or restarts a countdown.
REQ-008 SHALL have port i_cd_secs, input, 4 bits: countdown start value; sampled with i_cd_start.
REQ-009 SHALL have port i_cd_cancel, input, 1 bit: single-cycle pulse that aborts a countdown.
REQ-010 SHALL have port o_en, output, 1 bit: display enable for the 7-seg driver.
REQ-011 SHALL have port o_disp_mode, output, 1 bit: 0 = symbol, 1 = digit.
REQ-012 SHALL have port o_op_code, output, 3 bits: symbol to show.
REQ-013 SHALL have port o_digit_val, output, 4 bits: digit to show, 0-9.
REQ-014 SHALL have port o_busy, output, 1 bit: 1 while in state CD.
REQ-015 SHALL have port o_cd_done, output, 1 bit: one-cycle pulse when a countdown completes.

Function
REQ-016 SHALL implement the states IDLE, OP and CD; all outputs SHALL be registered.
REQ-017 In IDLE the outputs SHALL be o_en=0, o_disp_mode=0, o_busy=0, o_op_ready=1.
REQ-018 In OP the outputs SHALL be o_en=1, o_disp_mode=0, o_op_code=the latched code, o_op_ready=1.
REQ-019 In CD the outputs SHALL be o_en=1, o_disp_mode=1, o_digit_val=the current count, o_busy=1, o_op_ready=0.
REQ-020 An op handshake in IDLE or OP SHALL latch i_op_code and enter OP; the symbol appears on the outputs on the next cycle.
REQ-021 A later op handshake while in OP SHALL replace the latched code.
REQ-022 Codes 100-111 SHALL be latched unchanged; the driver blanks them.
REQ-023 i_cd_start SHALL enter CD from any state, with these load rules:
- count loads min(i_cd_secs, 9);
- the tick counter clears;
- the return state records IDLE or OP (a restart while in CD keeps the existing return state).
REQ-024 Each count value SHALL be displayed for exactly TICK_CYCLES cycles, so the sequence is N, N-1, ..., 0.
REQ-025 At the end of the period for count 0, the block SHALL pulse o_cd_done for 1 cycle and return to the return state; if that state is OP, it shows the previously latched code.
REQ-026 N=0 SHALL display 0 for one period and then complete normally.
REQ-027 Total countdown length SHALL be (N+1)*TICK_CYCLES cycles from the start pulse to the done pulse.
REQ-028 i_cd_cancel in CD SHALL return to the return state on the next cycle with no o_cd_done pulse; in IDLE or OP it SHALL be ignored.
REQ-029 Simultaneous i_cd_start and i_cd_cancel SHALL be resolved in favour of cancel; in IDLE or OP both are then ignored.
REQ-030 Simultaneous i_cd_start and an op handshake in IDLE or OP SHALL latch the op code, set the return state to OP, and enter CD.
REQ-031 i_op_valid in CD SHALL NOT be accepted; because o_op_ready=0, the requester holds the request until the countdown ends.
REQ-032 The tick counter SHALL count 0 to TICK_CYCLES-1 and wrap; its width is clog2(TICK_CYCLES).

Reset
REQ-033 rst=1 at a clock edge SHALL force: state IDLE; o_en=0; o_disp_mode=0; o_op_code=000; o_digit_val=0; o_busy=0; o_cd_done=0; o_op_ready=1; tick counter and count cleared.
REQ-034 Reset asserted in mid-countdown SHALL abort the countdown with no o_cd_done pulse.

Verification (TICK_CYCLES=4)
REQ-035 Op handshake: reset, then i_op_valid=1 with code 001 for 1 cycle -> next cycle o_en=1, o_disp_mode=0, o_op_code=001.
REQ-036 Normal countdown: in OP(001), i_cd_start with secs=2 -> o_digit_val 2,2,2,2,1,1,1,1,0,0,0,0; then o_cd_done=1 for 1 cycle; then OP with code 001.
REQ-037 Clamp and cancel: start with secs=12 -> digit 9 shown; cancel on cycle 5 -> IDLE, no o_cd_done pulse.
REQ-038 Blocked request and collision: i_op_valid held during CD -> o_op_ready=0 and not accepted until done; start and cancel in the same cycle -> no countdown starts.
REQ-039 Restart: i_cd_start with secs=1 while the count is 0 -> count reloads to 1 and o_cd_done occurs 8 cycles after the restart.
REQ-040 Reset in CD: rst=1 during CD with count 3 -> all outputs equal the REQ-033 reset values next cycle, with no o_cd_done pulse.
